// File: rtl/flash_mem_ctrl_pkg.sv
// Shared definitions for the flash memory controller.
//   clr_state_e  : bulk-clear FSM states
//   READ_LAT_*   : legal range of the read latency parameter
//   lane_merge() : per-byte select between old array data and new write data
package flash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/flash_mem_ctrl_if.sv
// Loader/fetch bus of the flash memory controller.
//   write side : wr_en, wr_addr, wr_data, wr_strb
//   read side  : rd_req, rd_addr -> rd_valid, rd_data
//   control    : clr_start -> busy, clr_done; ready = ~busy
// master modport is the requester (loader/fetch), slave is the memory.
interface flash_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_strb;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  ready;
  logic                  clr_start;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_req, rd_addr, clr_start,
    input  rd_valid, rd_data, ready, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_req, rd_addr, clr_start,
    output rd_valid, rd_data, ready, busy, clr_done
  );
endinterface

// File: rtl/flash_mem_ctrl_rd_pipe.sv
// Read-response delay line for the flash controller (1 or 2 stages).
//   clk, rst     : clock, async active-high reset
//   in_valid_i   : read accepted this cycle
//   in_data_i    : forwarded read word for that request
//   out_valid_o  : response valid, READ_LAT cycles after acceptance
//   out_data_o   : response data, holds its value while out_valid_o is low
module flash_rd_pipe
  import flash_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("flash_rd_pipe: READ_LAT must be 1 or 2");
  end

  logic              v1_q;
  logic [DATA_W-1:0] d1_q;

  // Stage-1 data only loads on a valid response so the output holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= in_valid_i;
      if (in_valid_i) d1_q <= in_data_i;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        d2_q <= d1_q;
      end
    end

    assign out_valid_o = v2_q;
    assign out_data_o  = d2_q;
  end else begin : g_lat1
    assign out_valid_o = v1_q;
    assign out_data_o  = d1_q;
  end

endmodule

// File: rtl/flash_mem_ctrl.sv
// Program/data flash array with byte-strobed write port, write-first read
// port, configurable read latency and a bulk-clear engine.
//   clk, rst : clock, async active-high reset
//   bus      : flash_mem_ctrl_if slave (write, read, clear control)
// Array contents are not reset; only control state is.
//
// state | meaning
// IDLE  | accepting reads/writes/clr_start
// CLEAR | writing CLEAR_VAL to word cnt_q each cycle, ready=0
// DONE  | one-cycle clr_done pulse, then IDLE
module flash_mem_ctrl
  import flash_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 15,
  parameter int              DEPTH     = 32768,
  parameter int              READ_LAT  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  flash_mem_ctrl_if.slave  bus
);

  localparam int                STRB_W    = DATA_W / 8;
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (DATA_W % 8 != 0) begin : g_bad_w
    $error("flash_mem_ctrl: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              busy;
  logic              ready;
  logic              wr_in_range, rd_in_range;
  logic              wr_fire, rd_fire, fwd_hit;
  logic [DATA_W-1:0] old_word, rd_word;
  logic              pipe_valid;
  logic [DATA_W-1:0] pipe_data;

  assign busy  = (state_q == CLEAR);
  assign ready = ~busy;

  // Extra top bit lets DEPTH == 2**ADDR_W compare correctly.
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);

  assign wr_fire = bus.wr_en & ready & wr_in_range;
  assign rd_fire = bus.rd_req & ready;
  assign fwd_hit = wr_fire & (bus.wr_addr == bus.rd_addr);

  // Write-first: a same-cycle write to the read address wins per strobed lane.
  always_comb begin
    old_word = mem_q[bus.rd_addr[IDX_W-1:0]];
    rd_word  = '0;
    if (rd_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        rd_word[8*b +: 8] = lane_merge(old_word[8*b +: 8], bus.wr_data[8*b +: 8],
                                       fwd_hit & bus.wr_strb[b]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q[IDX_W-1:0]] <= CLEAR_VAL;
    end else if (wr_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.wr_strb[b]) mem_q[bus.wr_addr[IDX_W-1:0]][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  flash_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (rd_fire),
    .in_data_i   (rd_word),
    .out_valid_o (pipe_valid),
    .out_data_o  (pipe_data)
  );

  assign bus.rd_valid = pipe_valid;
  assign bus.rd_data  = pipe_data;
  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.clr_done = (state_q == DONE);

endmodule

// File: tb/tb_flash_mem_ctrl.sv
module tb_flash_mem_ctrl;

  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_en = 1'b0, rd_req = 1'b0, clr_start = 1'b0;
  logic [6:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;

  flash_mem_ctrl_if #(.DATA_W(32), .ADDR_W(7)) ifc0 ();
  flash_mem_ctrl_if #(.DATA_W(32), .ADDR_W(7)) ifc1 ();
  flash_mem_ctrl_if #(.DATA_W(32), .ADDR_W(5)) ifc2 ();

  assign ifc0.wr_en = wr_en;  assign ifc0.wr_addr = wr_addr;       assign ifc0.wr_data = wr_data;
  assign ifc0.wr_strb = wr_strb; assign ifc0.rd_req = rd_req;      assign ifc0.rd_addr = rd_addr;
  assign ifc0.clr_start = clr_start;
  assign ifc1.wr_en = wr_en;  assign ifc1.wr_addr = wr_addr;       assign ifc1.wr_data = wr_data;
  assign ifc1.wr_strb = wr_strb; assign ifc1.rd_req = rd_req;      assign ifc1.rd_addr = rd_addr;
  assign ifc1.clr_start = clr_start;
  assign ifc2.wr_en = wr_en;  assign ifc2.wr_addr = wr_addr[4:0];  assign ifc2.wr_data = wr_data;
  assign ifc2.wr_strb = wr_strb; assign ifc2.rd_req = rd_req;      assign ifc2.rd_addr = rd_addr[4:0];
  assign ifc2.clr_start = clr_start;

  flash_mem_ctrl #(.DATA_W(32), .ADDR_W(7), .DEPTH(64), .READ_LAT(1), .CLEAR_VAL(CV))
    u0 (.clk(clk), .rst(rst), .bus(ifc0));
  flash_mem_ctrl #(.DATA_W(32), .ADDR_W(7), .DEPTH(64), .READ_LAT(2), .CLEAR_VAL(CV))
    u1 (.clk(clk), .rst(rst), .bus(ifc1));
  flash_mem_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LAT(1), .CLEAR_VAL(CV))
    u2 (.clk(clk), .rst(rst), .bus(ifc2));

  int checks = 0;
  int errors = 0;

  // Behavioural model: one word array per instance, a clear countdown and a
  // short history of accepted read responses indexed by latency.
  logic [31:0] mm [3][64];
  int          clr_left [3];
  int          clr_pos  [3];
  bit          done_m   [3];
  bit          hv [3][2];
  logic [31:0] hd [3][2];
  bit          ev [3];
  logic [31:0] ed [3];

  function automatic int dep(int i);   return (i == 2) ? 16 : 64;  endfunction
  function automatic int amask(int i); return (i == 2) ? 31 : 127; endfunction
  function automatic int lat(int i);   return (i == 1) ? 2 : 1;    endfunction

  task automatic model_edge(int i);
    int aw, ar;
    bit idle, pd, nv;
    logic [31:0] nd;
    aw   = int'(wr_addr) & amask(i);
    ar   = int'(rd_addr) & amask(i);
    idle = (clr_left[i] == 0);
    pd   = done_m[i];
    nv   = 1'b0;
    nd   = '0;
    if (idle && rd_req) begin
      nv = 1'b1;
      if (ar < dep(i)) begin
        nd = mm[i][ar];
        if (wr_en && aw == ar)
          for (int b = 0; b < 4; b++) if (wr_strb[b]) nd[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    hv[i][1] = hv[i][0]; hd[i][1] = hd[i][0];
    hv[i][0] = nv;       hd[i][0] = nd;
    ev[i] = hv[i][lat(i)-1];
    if (ev[i]) ed[i] = hd[i][lat(i)-1];
    if (idle && wr_en && aw < dep(i))
      for (int b = 0; b < 4; b++) if (wr_strb[b]) mm[i][aw][8*b +: 8] = wr_data[8*b +: 8];
    done_m[i] = 1'b0;
    if (!idle) begin
      mm[i][clr_pos[i]] = CV;
      clr_pos[i]++;
      clr_left[i]--;
      if (clr_left[i] == 0) done_m[i] = 1'b1;
    end else if (clr_start && !pd) begin
      clr_left[i] = dep(i);
      clr_pos[i]  = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        clr_left[i] = 0; clr_pos[i] = 0; done_m[i] = 1'b0;
        hv[i][0] = 1'b0; hv[i][1] = 1'b0; hd[i][0] = '0; hd[i][1] = '0;
        ev[i] = 1'b0; ed[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) model_edge(i);
    end
  end

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d got %h want %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int i, input logic b, input logic r, input logic d,
                          input logic v, input logic [31:0] dat);
    check("busy",     i, {31'b0, b}, {31'b0, clr_left[i] > 0});
    check("ready",    i, {31'b0, r}, {31'b0, clr_left[i] == 0});
    check("clr_done", i, {31'b0, d}, {31'b0, done_m[i]});
    check("rd_valid", i, {31'b0, v}, {31'b0, ev[i]});
    check("rd_data",  i, dat, ed[i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk_inst(0, ifc0.busy, ifc0.ready, ifc0.clr_done, ifc0.rd_valid, ifc0.rd_data);
      chk_inst(1, ifc1.busy, ifc1.ready, ifc1.clr_done, ifc1.rd_valid, ifc1.rd_data);
      chk_inst(2, ifc2.busy, ifc2.ready, ifc2.clr_done, ifc2.rd_valid, ifc2.rd_data);
    end
  end

  task automatic rd_once(input logic [6:0] a);
    @(negedge clk); rd_req = 1'b1; rd_addr = a;
    @(negedge clk); rd_req = 1'b0;
  endtask

  task automatic wr_once(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(negedge clk); wr_en = 1'b0;
  endtask

  function automatic bit any_active();
    for (int i = 0; i < 3; i++) if (clr_left[i] != 0 || done_m[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0, nb2, nd2;
    bit hit;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",    0, {31'b0, ifc0.ready},    32'd1);
    check("rst_busy",     0, {31'b0, ifc0.busy},     32'd0);
    check("rst_rd_valid", 0, {31'b0, ifc0.rd_valid}, 32'd0);
    check("rst_rd_data",  0, ifc0.rd_data,           32'd0);

    // Bulk clear, with requests and a second clr_start while busy.
    @(negedge clk); clr_start = 1'b1;
    nb0 = 0; nb2 = 0; nd2 = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0) clr_start = 1'b0;
      if (ifc0.busy) nb0++;
      if (ifc2.busy) nb2++;
      if (ifc2.clr_done) nd2++;
      if (k == 4) begin
        wr_en = 1'b1; wr_addr = 7'd3; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        rd_req = 1'b1; rd_addr = 7'd3; clr_start = 1'b1;
      end
      if (k == 5) begin wr_en = 1'b0; rd_req = 1'b0; clr_start = 1'b0; end
    end
    check("busy_len16", 2, nb2, 32'd16);
    check("busy_len64", 0, nb0, 32'd64);
    check("done_pulses", 2, nd2, 32'd1);

    for (int a = 0; a < 16; a++) rd_once(7'(a));
    check("clr_word15", 2, ifc2.rd_data, CV);

    // Out-of-range write/read on the 16-word instance.
    wr_once(7'd20, 32'h1234_5678, 4'hF);
    rd_once(7'd20);
    check("oor_valid", 2, {31'b0, ifc2.rd_valid}, 32'd1);
    check("oor_data",  2, ifc2.rd_data, 32'd0);
    check("inr_data",  0, ifc0.rd_data, 32'h1234_5678);

    // Basic write/read latency.
    wr_once(7'h10, 32'hDEADBEEF, 4'hF);
    rd_once(7'h10);
    check("lat1_valid", 0, {31'b0, ifc0.rd_valid}, 32'd1);
    check("lat1_data",  0, ifc0.rd_data, 32'hDEADBEEF);
    check("lat2_early", 1, {31'b0, ifc1.rd_valid}, 32'd0);
    @(negedge clk);
    check("lat2_valid", 1, {31'b0, ifc1.rd_valid}, 32'd1);
    check("lat2_data",  1, ifc1.rd_data, 32'hDEADBEEF);

    // Write-first forwarding with partial strobes.
    wr_once(7'h20, 32'h11223344, 4'hF);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 7'h20; wr_data = 32'hAABBCCDD; wr_strb = 4'b0101;
    rd_req = 1'b1; rd_addr = 7'h20;
    @(negedge clk);
    wr_en = 1'b0; rd_req = 1'b0;
    check("fwd_lat1", 0, ifc0.rd_data, 32'h11BB33DD);
    @(negedge clk);
    check("fwd_lat2", 1, ifc1.rd_data, 32'h11BB33DD);
    rd_once(7'h20);
    check("fwd_after", 0, ifc0.rd_data, 32'h11BB33DD);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 1) == 1);
      rd_req  = ($urandom_range(0, 1) == 1);
      wr_addr = 7'($urandom_range(0, 79));
      rd_addr = ($urandom_range(0, 9) < 3) ? wr_addr : 7'($urandom_range(0, 79));
      wr_data = $urandom;
      wr_strb = 4'($urandom_range(0, 15));
      clr_start = ($urandom_range(0, 149) == 0) && !any_active();
    end
    @(negedge clk);
    wr_en = 1'b0; rd_req = 1'b0; clr_start = 1'b0;

    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!any_active()) begin hit = 1'b1; break; end
    end
    check("idle_wait", 0, {31'b0, hit}, 32'd1);

    // Reset during clear at counter 5.
    for (int a = 0; a < 16; a++) wr_once(7'(a), 32'h0000_1000 + 32'(a), 4'hF);
    @(negedge clk); clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (clr_pos[2] == 5) begin hit = 1'b1; break; end
    end
    check("reach_cnt5", 2, {31'b0, hit}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_busy0",  0, {31'b0, ifc0.busy},     32'd0);
    check("arst_busy2",  2, {31'b0, ifc2.busy},     32'd0);
    check("arst_done2",  2, {31'b0, ifc2.clr_done}, 32'd0);
    check("arst_valid2", 2, {31'b0, ifc2.rd_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 2, {31'b0, ifc2.busy}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd_once(7'(a));
      if (a == 4) check("partial_w4", 2, ifc2.rd_data, CV);
      if (a == 5) check("partial_w5", 2, ifc2.rd_data, 32'h0000_1005);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_mem_ctrl.md
Name: flash_mem_ctrl

Overview:
Parametrised single-clock program/data memory, the next generation of the SoC instruction flash array. It provides one write port with byte strobes, one read port with write-first forwarding, and a configurable read latency of 1 or 2. A built-in bulk-clear engine walks the whole array so the loader can wipe flash before reprogramming. It sits between the UART/JTAG program loader (write side) and the core fetch unit (read side).

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
ADDR_W, 15, word-address width.
DEPTH, 32768, number of words; 1 <= DEPTH <= 2**ADDR_W.
READ_LAT, 1, read latency in cycles; only 1 or 2 are legal, anything else is an elaboration error.
CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear engine.

Ports:
clk  in  1  single clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
wr_en  in  1  write request.
wr_addr  in  ADDR_W  write word address.
wr_data  in  DATA_W  write data.
wr_strb  in  DATA_W/8  byte-lane enables; bit i covers bits [8i+7:8i].
rd_req  in  1  read request.
rd_addr  in  ADDR_W  read word address.
rd_valid  out  1  rd_data is valid this cycle.
rd_data  out  DATA_W  read data.
ready  out  1  high when wr_en, rd_req and clr_start are accepted; equals ~busy.
clr_start  in  1  start a bulk clear.
busy  out  1  clear engine active.
clr_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- Reset (asynchronous): rd_valid=0, rd_data=0, busy=0, clr_done=0, FSM=IDLE, clear counter=0, read pipeline valid bits=0. Array contents are not reset.
- Write: when wr_en && ready, at the clock edge each byte lane whose wr_strb bit is set is updated. Lanes with the strobe clear are unchanged. wr_strb=0 is a no-op.
- Read: when rd_req && ready in cycle N, rd_valid=1 and rd_data are presented in cycle N+READ_LAT. There is no back-pressure; a new read is accepted every cycle.
- Forwarding (write-first): if a write and a read are accepted in the same cycle at the same address, the returned data per lane is wr_data when the strobe is set, else the old array lane. A write to that address in a later cycle does not alter data already captured in the read pipeline.
- READ_LAT=2: stage 2 registers stage-1 data and valid unchanged.
- Out-of-range address (addr >= DEPTH): writes are ignored; reads return 0 with rd_valid=1.
- rd_data holds its last value when rd_valid=0.
- Clear FSM states:
  - IDLE: clr_start && ready -> CLEAR, counter=0. Reads and writes accepted in the same cycle as clr_start are still serviced.
  - CLEAR: busy=1 and ready=0; writes CLEAR_VAL to address counter each cycle and increments the counter. After writing DEPTH-1 -> DONE.
  - DONE: clr_done=1 for one cycle, busy=0 -> IDLE.
- Clear timing: busy is high for exactly DEPTH cycles, starting the cycle after clr_start.
- Requests during busy: wr_en, rd_req and clr_start are ignored and produce no read response. Read responses already in the pipeline when busy rises still emerge.
- Reset during CLEAR aborts the clear immediately. The array is left partially cleared and clr_done does not pulse.

Decomposition:
- Shared package flash_pkg holds: the clear-FSM state enum (IDLE/CLEAR/DONE), the lane-merge function (old, new, strb), and READ_LAT legality constants.
- One sub-module flash_rd_pipe (parametrised by DATA_W and READ_LAT) implements the valid/data delay stages. Array, forwarding and FSM stay in the top module.

Test Plan:
- Reset then write 0xDEADBEEF @0x10 with strb=4'hF; read @0x10 -> READ_LAT=1: rd_valid=1 and rd_data=0xDEADBEEF exactly 1 cycle after rd_req. READ_LAT=2: same, 2 cycles after rd_req.
- Word @0x20=0x11223344; same cycle write 0xAABBCCDD strb=4'b0101 and read @0x20 -> rd_data=0x11BB33DD; a subsequent read also returns 0x11BB33DD.
- DEPTH=16, CLEAR_VAL=0xA5A5A5A5, pulse clr_start -> busy high 16 cycles, ready low throughout, clr_done pulses once; reads of 0..15 then return 0xA5A5A5A5.
- Issue wr_en and rd_req while busy=1 -> no array change and no rd_valid. clr_start while busy -> no restart (busy length stays 16).
- Assert rst at clear counter=5 (DEPTH=16) -> busy, rd_valid and clr_done drop asynchronously; words 0..4 equal CLEAR_VAL and words 5..15 keep their prior contents.
- DEPTH=16, ADDR_W=5: write @20 then read @20 -> array unchanged, rd_valid=1 with rd_data=0.
